// File: rtl/karateka_pkg.sv
// Constants shared by the karateka referee and the screen controller:
// referee state encoding, the start key and the screen codes.
package karateka_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIGHT     = 3'd1,
        ST_KO_ENEMY  = 3'd2,
        ST_KO_PLAYER = 3'd3,
        ST_WIN       = 3'd4,
        ST_LOSE      = 3'd5
    } referee_state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [7:0] SCREEN_TITLE   = 8'h00;
    localparam logic [7:0] SCREEN_FIGHT   = 8'h01;
    localparam logic [7:0] SCREEN_VICTORY = 8'h02;
    localparam logic [7:0] SCREEN_DEFEAT  = 8'h03;

endpackage

// File: rtl/combat_referee_if.sv
// Frame, keyboard and hit inputs plus health/outcome outputs of the referee.
interface combat_referee_if #(
    parameter int unsigned HP_W = 4
);
    logic            frame_tick;
    logic [7:0]      keycode;
    logic            player_hit;
    logic            enemy_hit;
    logic [HP_W-1:0] player_hp;
    logic [HP_W-1:0] enemy_hp;
    logic            player_invuln;
    logic            enemy_invuln;
    logic            fight_active;
    logic            VICTORY_sig;
    logic            DEFEAT_sig;

    modport master (
        output frame_tick, keycode, player_hit, enemy_hit,
        input  player_hp, enemy_hp, player_invuln, enemy_invuln,
               fight_active, VICTORY_sig, DEFEAT_sig
    );

    modport slave (
        input  frame_tick, keycode, player_hit, enemy_hit,
        output player_hp, enemy_hp, player_invuln, enemy_invuln,
               fight_active, VICTORY_sig, DEFEAT_sig
    );
endinterface

// File: rtl/combat_referee_fighter_health.sv
// One fighter's health register and invulnerability window; ko flags that
// health reaches zero at the coming edge so the FSM can react in step.
module fighter_health #(
    parameter int unsigned HP_MAX  = 8,
    parameter int unsigned HP_W    = 4,
    parameter int unsigned IFRAMES = 30
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            load,
    input  logic            hit,
    input  logic            frame_tick,
    input  logic            enable,
    output logic [HP_W-1:0] hp,
    output logic            invuln,
    output logic            ko
);
    localparam int unsigned CW = $clog2(IFRAMES + 1);

    logic [CW-1:0]   iframe_cnt;
    logic [CW-1:0]   iframe_next;
    logic [HP_W-1:0] hp_next;
    logic            accept;

    // A fresh hit reloads the window even when a frame tick lands on the same cycle.
    always_comb begin
        accept      = enable && hit && (iframe_cnt == '0);
        hp_next     = hp;
        iframe_next = iframe_cnt;
        if (load) begin
            hp_next     = HP_W'(HP_MAX);
            iframe_next = '0;
        end else if (accept) begin
            hp_next     = (hp == '0) ? '0 : hp - 1'b1;
            iframe_next = CW'(IFRAMES);
        end else if (frame_tick && (iframe_cnt != '0)) begin
            iframe_next = iframe_cnt - 1'b1;
        end
    end

    assign ko = (hp_next == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hp         <= '0;
            iframe_cnt <= '0;
            invuln     <= 1'b0;
        end else begin
            hp         <= hp_next;
            iframe_cnt <= iframe_next;
            invuln     <= (iframe_next != '0);
        end
    end
endmodule

// File: rtl/combat_referee.sv
// Fight referee: tracks both fighters' health, and after a knockout delay
// holds the victory or defeat level for the screen controller.
module combat_referee
    import karateka_pkg::*;
#(
    parameter int unsigned HP_MAX    = 8,
    parameter int unsigned HP_W      = 4,
    parameter int unsigned IFRAMES   = 30,
    parameter int unsigned KO_FRAMES = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    combat_referee_if.slave   bus
);
    localparam int unsigned KW = $clog2(KO_FRAMES + 1);

    referee_state_t state;
    referee_state_t state_next;
    logic [KW-1:0]  ko_cnt;
    logic [KW-1:0]  ko_next;
    logic           start;
    logic           in_fight;
    logic           player_ko;
    logic           enemy_ko;

    assign start    = (state == ST_IDLE) && (bus.keycode == KEY_SPACE);
    assign in_fight = (state == ST_FIGHT);

    fighter_health #(
        .HP_MAX  (HP_MAX),
        .HP_W    (HP_W),
        .IFRAMES (IFRAMES)
    ) u_player (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (start),
        .hit        (bus.player_hit),
        .frame_tick (bus.frame_tick),
        .enable     (in_fight),
        .hp         (bus.player_hp),
        .invuln     (bus.player_invuln),
        .ko         (player_ko)
    );

    fighter_health #(
        .HP_MAX  (HP_MAX),
        .HP_W    (HP_W),
        .IFRAMES (IFRAMES)
    ) u_enemy (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (start),
        .hit        (bus.enemy_hit),
        .frame_tick (bus.frame_tick),
        .enable     (in_fight),
        .hp         (bus.enemy_hp),
        .invuln     (bus.enemy_invuln),
        .ko         (enemy_ko)
    );

    // Player KO is tested first so a double knockout counts as a defeat.
    always_comb begin
        state_next = state;
        ko_next    = ko_cnt;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FIGHT;
            end
            ST_FIGHT: begin
                if (player_ko) begin
                    state_next = ST_KO_PLAYER;
                    ko_next    = KW'(KO_FRAMES);
                end else if (enemy_ko) begin
                    state_next = ST_KO_ENEMY;
                    ko_next    = KW'(KO_FRAMES);
                end
            end
            ST_KO_PLAYER, ST_KO_ENEMY: begin
                if (bus.frame_tick) begin
                    ko_next = (ko_cnt == '0) ? '0 : ko_cnt - 1'b1;
                    if (ko_cnt <= KW'(1)) begin
                        if (state == ST_KO_PLAYER) state_next = ST_LOSE;
                        else                       state_next = ST_WIN;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= ST_IDLE;
            ko_cnt           <= '0;
            bus.fight_active <= 1'b0;
            bus.VICTORY_sig  <= 1'b0;
            bus.DEFEAT_sig   <= 1'b0;
        end else begin
            state            <= state_next;
            ko_cnt           <= ko_next;
            bus.fight_active <= (state_next == ST_FIGHT);
            bus.VICTORY_sig  <= (state_next == ST_WIN);
            bus.DEFEAT_sig   <= (state_next == ST_LOSE);
        end
    end
endmodule

// File: tb/tb_combat_referee.sv
// Directed bench for combat_referee with HP_MAX=8, IFRAMES=30, KO_FRAMES=16.
module tb_combat_referee;

    logic Clk;
    logic Reset_n;
    int   total;
    int   bad;

    combat_referee_if #(.HP_W(4)) bus ();

    combat_referee #(
        .HP_MAX    (8),
        .HP_W      (4),
        .IFRAMES   (30),
        .KO_FRAMES (16)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic start_fight();
        bus.keycode = 8'h2C;
        step();
        bus.keycode = 8'h00;
    endtask

    task automatic hit(input logic p, input logic e);
        bus.player_hit = p;
        bus.enemy_hit  = e;
        step();
        bus.player_hit = 1'b0;
        bus.enemy_hit  = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.frame_tick = 1'b0; bus.keycode = 8'h00;
        bus.player_hit = 1'b0; bus.enemy_hit = 1'b0;
        repeat (3) step();
        total++; if (bus.player_hp !== 4'd0 || bus.enemy_hp !== 4'd0) begin bad++; $display("FAIL rst_hp: got %0d/%0d want 0/0", bus.player_hp, bus.enemy_hp); end
        total++; if ({bus.fight_active, bus.VICTORY_sig, bus.DEFEAT_sig, bus.player_invuln, bus.enemy_invuln} !== 5'b0) begin bad++; $display("FAIL rst_flags: got %b want 00000", {bus.fight_active, bus.VICTORY_sig, bus.DEFEAT_sig, bus.player_invuln, bus.enemy_invuln}); end
        Reset_n = 1'b1;
        step();
        bus.keycode = 8'h2B;
        hit(1'b1, 1'b1);
        step(); step();
        bus.keycode = 8'h00;
        total++; if (bus.fight_active !== 1'b0) begin bad++; $display("FAIL idle_stay: got %b want 0", bus.fight_active); end
        total++; if (bus.player_hp !== 4'd0 || bus.enemy_hp !== 4'd0) begin bad++; $display("FAIL idle_hp: got %0d/%0d want 0/0", bus.player_hp, bus.enemy_hp); end
        start_fight();
        total++; if (bus.fight_active !== 1'b1) begin bad++; $display("FAIL start_active: got %b want 1", bus.fight_active); end
        total++; if (bus.player_hp !== 4'd8 || bus.enemy_hp !== 4'd8) begin bad++; $display("FAIL start_hp: got %0d/%0d want 8/8", bus.player_hp, bus.enemy_hp); end
    endtask

    task automatic test_hit_invuln();
        bus.enemy_hit = 1'b1;
        step();
        total++; if (bus.enemy_hp !== 4'd7 || bus.enemy_invuln !== 1'b1) begin bad++; $display("FAIL hit1: got hp=%0d inv=%b want 7/1", bus.enemy_hp, bus.enemy_invuln); end
        total++; if (bus.player_hp !== 4'd8) begin bad++; $display("FAIL hit1_player: got %0d want 8", bus.player_hp); end
        step();
        bus.enemy_hit = 1'b0;
        total++; if (bus.enemy_hp !== 4'd7) begin bad++; $display("FAIL repeat_pulse: got %0d want 7", bus.enemy_hp); end
        frames(3);
        hit(1'b0, 1'b1);
        total++; if (bus.enemy_hp !== 4'd7) begin bad++; $display("FAIL invuln_reject: got %0d want 7", bus.enemy_hp); end
        frames(26);
        total++; if (bus.enemy_invuln !== 1'b1) begin bad++; $display("FAIL invuln_29: got %b want 1", bus.enemy_invuln); end
        frames(1);
        total++; if (bus.enemy_invuln !== 1'b0) begin bad++; $display("FAIL invuln_30: got %b want 0", bus.enemy_invuln); end
        hit(1'b0, 1'b1);
        total++; if (bus.enemy_hp !== 4'd6 || bus.enemy_invuln !== 1'b1) begin bad++; $display("FAIL hit2: got hp=%0d inv=%b want 6/1", bus.enemy_hp, bus.enemy_invuln); end
    endtask

    task automatic test_tick_coincide();
        bus.enemy_hit = 1'b1; bus.frame_tick = 1'b1;
        step();
        bus.enemy_hit = 1'b0; bus.frame_tick = 1'b0;
        total++; if (bus.enemy_hp !== 4'd6) begin bad++; $display("FAIL tick_reject: got %0d want 6", bus.enemy_hp); end
        frames(28);
        total++; if (bus.enemy_invuln !== 1'b1) begin bad++; $display("FAIL tick_dec_a: got %b want 1", bus.enemy_invuln); end
        frames(1);
        total++; if (bus.enemy_invuln !== 1'b0) begin bad++; $display("FAIL tick_dec_b: got %b want 0", bus.enemy_invuln); end
        bus.enemy_hit = 1'b1; bus.frame_tick = 1'b1;
        step();
        bus.enemy_hit = 1'b0; bus.frame_tick = 1'b0;
        total++; if (bus.enemy_hp !== 4'd5) begin bad++; $display("FAIL tick_accept: got %0d want 5", bus.enemy_hp); end
        frames(29);
        total++; if (bus.enemy_invuln !== 1'b1) begin bad++; $display("FAIL load_beats_a: got %b want 1", bus.enemy_invuln); end
        frames(1);
        total++; if (bus.enemy_invuln !== 1'b0) begin bad++; $display("FAIL load_beats_b: got %b want 0", bus.enemy_invuln); end
    endtask

    task automatic test_reset_mid();
        hit(1'b1, 1'b1);
        frames(30);
        hit(1'b1, 1'b1);
        frames(30);
        hit(1'b1, 1'b0);
        total++; if (bus.player_hp !== 4'd5 || bus.enemy_hp !== 4'd3 || bus.fight_active !== 1'b1) begin bad++; $display("FAIL pre_reset: got %0d/%0d act=%b want 5/3 1", bus.player_hp, bus.enemy_hp, bus.fight_active); end
        Reset_n = 1'b0;
        #2;
        total++; if (bus.player_hp !== 4'd0 || bus.enemy_hp !== 4'd0) begin bad++; $display("FAIL async_hp: got %0d/%0d want 0/0", bus.player_hp, bus.enemy_hp); end
        total++; if ({bus.fight_active, bus.VICTORY_sig, bus.DEFEAT_sig, bus.player_invuln, bus.enemy_invuln} !== 5'b0) begin bad++; $display("FAIL async_flags: got %b want 00000", {bus.fight_active, bus.VICTORY_sig, bus.DEFEAT_sig, bus.player_invuln, bus.enemy_invuln}); end
        Reset_n = 1'b1;
        step();
        start_fight();
        total++; if (bus.player_hp !== 4'd8 || bus.enemy_hp !== 4'd8 || bus.fight_active !== 1'b1) begin bad++; $display("FAIL restart: got %0d/%0d act=%b want 8/8 1", bus.player_hp, bus.enemy_hp, bus.fight_active); end
    endtask

    task automatic test_victory();
        logic hold_ok;
        for (int i = 0; i < 7; i++) begin
            hit(1'b0, 1'b1);
            frames(31);
        end
        total++; if (bus.enemy_hp !== 4'd1) begin bad++; $display("FAIL seven_hits: got %0d want 1", bus.enemy_hp); end
        hit(1'b0, 1'b1);
        total++; if (bus.enemy_hp !== 4'd0 || bus.fight_active !== 1'b0 || bus.VICTORY_sig !== 1'b0) begin bad++; $display("FAIL ko_enemy: got hp=%0d act=%b vic=%b want 0 0 0", bus.enemy_hp, bus.fight_active, bus.VICTORY_sig); end
        hit(1'b1, 1'b0);
        frames(15);
        total++; if (bus.VICTORY_sig !== 1'b0 || bus.player_hp !== 4'd8) begin bad++; $display("FAIL ko_wait: got vic=%b php=%0d want 0 8", bus.VICTORY_sig, bus.player_hp); end
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        total++; if (bus.VICTORY_sig !== 1'b1 || bus.DEFEAT_sig !== 1'b0) begin bad++; $display("FAIL victory_rise: got vic=%b def=%b want 1 0", bus.VICTORY_sig, bus.DEFEAT_sig); end
        hold_ok = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            bus.keycode    = (c % 5 == 0) ? 8'h2C : 8'h00;
            bus.player_hit = (c % 7 == 0);
            bus.enemy_hit  = (c % 11 == 0);
            bus.frame_tick = (c % 3 == 0);
            step();
            if (bus.VICTORY_sig !== 1'b1 || bus.DEFEAT_sig !== 1'b0 || bus.fight_active !== 1'b0 || bus.player_hp !== 4'd8) hold_ok = 1'b0;
        end
        bus.keycode = 8'h00; bus.player_hit = 1'b0; bus.enemy_hit = 1'b0; bus.frame_tick = 1'b0;
        total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL victory_hold: got %b want 1 (vic=%b def=%b act=%b php=%0d)", hold_ok, bus.VICTORY_sig, bus.DEFEAT_sig, bus.fight_active, bus.player_hp); end
    endtask

    task automatic test_double_ko();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
        start_fight();
        for (int i = 0; i < 7; i++) begin
            hit(1'b1, 1'b1);
            frames(31);
        end
        total++; if (bus.player_hp !== 4'd1 || bus.enemy_hp !== 4'd1) begin bad++; $display("FAIL both_one: got %0d/%0d want 1/1", bus.player_hp, bus.enemy_hp); end
        hit(1'b1, 1'b1);
        total++; if (bus.player_hp !== 4'd0 || bus.enemy_hp !== 4'd0 || bus.fight_active !== 1'b0) begin bad++; $display("FAIL double_ko: got %0d/%0d act=%b want 0/0 0", bus.player_hp, bus.enemy_hp, bus.fight_active); end
        frames(15);
        total++; if (bus.DEFEAT_sig !== 1'b0) begin bad++; $display("FAIL defeat_early: got %b want 0", bus.DEFEAT_sig); end
        frames(1);
        total++; if (bus.DEFEAT_sig !== 1'b1 || bus.VICTORY_sig !== 1'b0) begin bad++; $display("FAIL defeat_rise: got def=%b vic=%b want 1 0", bus.DEFEAT_sig, bus.VICTORY_sig); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hit_invuln();
        test_tick_coincide();
        test_reset_mid();
        test_victory();
        test_double_ko();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
